// File: rtl/team_06_pwm_audio_out.sv
`default_nettype none
// ============================================================================
// Module   : team_06_pwm_audio_out
// Purpose  : Last stage of the volume path. Accepts 16-bit unsigned samples
//            over a valid/ready handshake, buffers them in a small FIFO and
//            plays one sample per PWM period as a single-bit waveform for the
//            RC-filtered speaker pin. The duty of a period is the top PWM_BITS
//            bits of its sample; the lower bits are truncated.
//
// Parameters:
//   PWM_BITS    PWM resolution, period = 2**PWM_BITS clocks (<= 16)
//   FIFO_DEPTH  sample buffer entries (power of 2, >= 2)
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   sample_in      unsigned sample from the volume stage
//   sample_valid   sample_in valid this cycle
//   sample_ready   FIFO can accept (not full)
//   enable         playback enable
//   pwm_out        registered PWM output
//   period_start   high in RUN while the PWM counter is 0
//   underrun       one-cycle pulse: period wrapped with the FIFO empty
//   fifo_level     entries currently held
//   underrun_count saturating underrun counter (PWM_UNDERRUN_CNT_EN only)
//
// Build option:
//   PWM_UNDERRUN_CNT_EN  when defined, adds the 8-bit saturating
//                        underrun_count output, cleared only by rst.
//
// Revision : 1.0  initial release
// ============================================================================
module team_06_pwm_audio_out #(
    parameter int PWM_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          enable,
    output logic                          pwm_out,
    output logic                          period_start,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PWM_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                    underrun_count
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [PWM_BITS-1:0] c_CNT_MAX  = '1;
    localparam logic [c_LVL_W-1:0]  c_FULL_LVL = c_LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [PWM_BITS-1:0]   r_cnt;
    logic [PWM_BITS-1:0]   r_duty;
    logic                  r_pwm;
    logic                  r_underrun;
    logic [PWM_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_LVL_W-1:0]    r_level;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [PWM_BITS-1:0]   w_cnt_nxt;
    logic [PWM_BITS-1:0]   w_duty_nxt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_underrun_set;
    logic                  w_full;
    logic                  w_empty;
    logic [PWM_BITS-1:0]   w_head_duty;
    logic [PWM_BITS-1:0]   w_in_duty;

    // Only the duty bits ever reach the output, so only those are stored.
    assign w_in_duty = sample_in[15 -: PWM_BITS];

    generate
        if (PWM_BITS < 16) begin : g_trunc
            // Truncated sample LSBs are intentionally discarded.
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^sample_in[15-PWM_BITS:0];
        end
    endgenerate

    assign w_full       = (r_level == c_FULL_LVL);
    assign w_empty      = (r_level == '0);
    assign w_push       = sample_valid && !w_full;
    assign w_head_duty  = r_mem[r_rptr];

    assign sample_ready = !w_full;
    assign fifo_level   = r_level;
    assign pwm_out      = r_pwm;
    assign underrun     = r_underrun;
    assign period_start = (r_state == S_RUN) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by r_level)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in_duty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Playback FSM: next-state / datapath decode
    // ------------------------------------------------------------------
    // Pops are only issued from the registered (start-of-cycle) level, so
    // a sample pushed into an empty FIFO is first visible a cycle later.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_duty_nxt     = r_duty;
        w_pop          = 1'b0;
        w_underrun_set = 1'b0;

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_duty_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_PRIME;
                end
                S_PRIME: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_duty_nxt  = w_head_duty;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == c_CNT_MAX) begin
                        w_cnt_nxt = '0;
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_duty_nxt = w_head_duty;
                        end else begin
                            // Starved: replay the previous duty.
                            w_underrun_set = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + PWM_BITS'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_duty     <= '0;
            r_pwm      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_duty     <= w_duty_nxt;
            r_underrun <= w_underrun_set;
            // Output trails the counter by one clock. Qualifying with
            // enable makes the pin drop on the same edge that leaves RUN.
            r_pwm      <= enable && (r_state == S_RUN) && (r_cnt < r_duty);
        end
    end

`ifdef PWM_UNDERRUN_CNT_EN
    // ------------------------------------------------------------------
    // Saturating underrun counter
    // ------------------------------------------------------------------
    logic [7:0] r_underrun_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun_count <= '0;
        end else if (w_underrun_set && (r_underrun_count != 8'hFF)) begin
            r_underrun_count <= r_underrun_count + 8'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_team_06_pwm_audio_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_team_06_pwm_audio_out
// Purpose  : Self-checking bench for team_06_pwm_audio_out. Accepted samples
//            push their expected duty into a scoreboard queue; each measured
//            PWM period pops the queue (or replays the last duty when empty)
//            and compares high-time, period_start and underrun.
// Revision : 1.0  initial release
// ============================================================================
module tb_team_06_pwm_audio_out;

    localparam int PWM_BITS   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PERIOD     = 1 << PWM_BITS;

    logic        clk;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        enable;
    logic        pwm_out;
    logic        period_start;
    logic        underrun;
    logic [2:0]  fifo_level;
`ifdef PWM_UNDERRUN_CNT_EN
    logic [7:0]  underrun_count;
`endif

    team_06_pwm_audio_out #(
        .PWM_BITS   (PWM_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .enable         (enable),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .underrun       (underrun),
        .fifo_level     (fifo_level)
`ifdef PWM_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int last_duty = 0;
    int meas_first = 0;

    // Drive one sample for one clock. The scoreboard takes it only if the
    // model says the FIFO has room.
    task automatic push_sample(input logic [15:0] s);
        bit exp_acc;
        exp_acc      = (exp_q.size() < FIFO_DEPTH);
        sample_in    = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (exp_acc) exp_q.push_back(int'(s[15:8]));
    endtask

    task automatic wait_period_start(input string tag);
        int i;
        i = 0;
        while (period_start !== 1'b1 && i < 600) begin
            @(negedge clk);
            i++;
        end
        if (period_start !== 1'b1) begin
            n_checks++;
            $display("FAIL %s_wait: period_start not seen within 600 cycles", tag);
        end
    endtask

    // Called at the negedge where period_start is high. Samples the 256
    // following negedges, which carry pwm for cnt = 0..255 of this period.
    task automatic measure_period(input string tag);
        int  d;
        int  hi;
        int  ps_cnt;
        bit  exp_ur;
        if (exp_q.size() > 0) d = exp_q.pop_front();
        else                  d = last_duty;
        last_duty = d;
        exp_ur = (exp_q.size() == 0);
        hi = 0;
        ps_cnt = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (i == 0) meas_first = int'(pwm_out);
            hi     += int'(pwm_out);
            ps_cnt += int'(period_start);
        end
        n_checks++;
        if (hi != d) $display("FAIL %s_high: got %0d high clocks want %0d", tag, hi, d);
        else n_pass++;
        n_checks++;
        if (ps_cnt != 1 || period_start !== 1'b1)
            $display("FAIL %s_pstart: got %0d pulses (end=%b) want 1 at period end", tag, ps_cnt, period_start);
        else n_pass++;
        n_checks++;
        if (underrun !== exp_ur) $display("FAIL %s_underrun: got %b want %b", tag, underrun, exp_ur);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pwm_out, period_start, underrun, sample_ready, fifo_level} !== 7'b0001_000)
            $display("FAIL reset_outputs: got pwm=%b ps=%b ur=%b rdy=%b lvl=%0d want 0 0 0 1 0",
                     pwm_out, period_start, underrun, sample_ready, fifo_level);
        else n_pass++;
`ifdef PWM_UNDERRUN_CNT_EN
        n_checks++;
        if (underrun_count !== 8'd0) $display("FAIL reset_ucount: got %0d want 0", underrun_count);
        else n_pass++;
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pwm_out !== 1'b0 || fifo_level !== 3'd0 || sample_ready !== 1'b1)
            $display("FAIL reset_idle: got pwm=%b lvl=%0d rdy=%b want 0 0 1", pwm_out, fifo_level, sample_ready);
        else n_pass++;
    endtask

    task automatic test_fifo_fill();
        for (int k = 0; k < 5; k++) begin
            bit exp_rdy;
            exp_rdy = (exp_q.size() < FIFO_DEPTH);
            n_checks++;
            if (sample_ready !== exp_rdy) $display("FAIL fill_ready%0d: got %b want %b", k, sample_ready, exp_rdy);
            else n_pass++;
            push_sample(16'((k + 1) << 12));
            n_checks++;
            if (fifo_level !== 3'(exp_q.size()))
                $display("FAIL fill_level%0d: got %0d want %0d", k, fifo_level, exp_q.size());
            else n_pass++;
        end
        n_checks++;
        if (sample_ready !== 1'b0) $display("FAIL fill_full_ready: got %b want 0", sample_ready);
        else n_pass++;
    endtask

    // Four queued samples play in order, then the last duty is held.
    task automatic test_fifo_order();
        enable = 1'b1;
        wait_period_start("order");
        for (int p = 0; p < 5; p++) measure_period($sformatf("order_p%0d", p));
    endtask

    task automatic test_enable_drop();
        repeat (5) @(negedge clk);
        n_checks++;
        if (pwm_out !== 1'b1) $display("FAIL drop_pre_pwm: got %b want 1", pwm_out);
        else n_pass++;
        push_sample(16'h2000);
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pwm_out !== 1'b0 || period_start !== 1'b0)
            $display("FAIL drop_pwm: got pwm=%b ps=%b want 0 0", pwm_out, period_start);
        else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'(exp_q.size()) || pwm_out !== 1'b0)
            $display("FAIL drop_level: got lvl=%0d pwm=%b want %0d 0", fifo_level, pwm_out, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        enable = 1'b1;
        last_duty = exp_q.pop_front();
        repeat (10) @(negedge clk);
        push_sample(16'h7000);
        n_checks++;
        if (pwm_out !== 1'b1 || fifo_level !== 3'd1)
            $display("FAIL midrst_pre: got pwm=%b lvl=%0d want 1 1", pwm_out, fifo_level);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({pwm_out, period_start, underrun, sample_ready, fifo_level} !== 7'b0001_000)
            $display("FAIL midrst_outputs: got pwm=%b ps=%b ur=%b rdy=%b lvl=%0d want 0 0 0 1 0",
                     pwm_out, period_start, underrun, sample_ready, fifo_level);
        else n_pass++;
        enable = 1'b0;
        exp_q.delete();
        last_duty = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Latency, underrun on starvation with held duty, then a new sample.
    task automatic test_basic();
        push_sample(16'h4000);
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pwm_out !== 1'b0 || period_start !== 1'b0)
            $display("FAIL basic_edge1: got pwm=%b ps=%b want 0 0", pwm_out, period_start);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (pwm_out !== 1'b0 || period_start !== 1'b1)
            $display("FAIL basic_edge2: got pwm=%b ps=%b want 0 1", pwm_out, period_start);
        else n_pass++;
        measure_period("basic_p0");
        n_checks++;
        if (meas_first != 1) $display("FAIL basic_edge3: got pwm=%0d want 1", meas_first);
        else n_pass++;
        measure_period("basic_held");
        push_sample(16'h8000);
        wait_period_start("basic");
        measure_period("basic_128");
    endtask

    task automatic test_zero_full();
        push_sample(16'h0000);
        push_sample(16'hFF00);
        wait_period_start("zf");
        measure_period("zf_zero");
        measure_period("zf_max");
    endtask

`ifdef PWM_UNDERRUN_CNT_EN
    task automatic test_underrun_count();
        enable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        push_sample(16'h4000);
        enable = 1'b1;
        wait_period_start("ucnt");
        repeat (3 * PERIOD + 10) @(negedge clk);
        n_checks++;
        if (underrun_count !== 8'd3) $display("FAIL ucnt_three: got %0d want 3", underrun_count);
        else n_pass++;
        repeat (297 * PERIOD) @(negedge clk);
        n_checks++;
        if (underrun_count !== 8'd255) $display("FAIL ucnt_sat: got %0d want 255", underrun_count);
        else n_pass++;
        enable = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'h0000;
        @(negedge clk);
        test_reset();
        test_fifo_fill();
        test_fifo_order();
        test_enable_drop();
        test_reset_midstream();
        test_basic();
        test_zero_full();
`ifdef PWM_UNDERRUN_CNT_EN
        test_underrun_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
